project287_display: RTL and testbench

PROJECT287_DISPLAY -- requirements
Module: project287

---
 rtl/project287_display.sv | 71 +++++++
 tb/tb_project287_display.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/project287_display.sv
// project287_display: free-running double-dabble binary-to-BCD converter driving eight blanked 7-segment digits
module project287_display (
    input  logic        clk,
    input  logic        rst,
    input  logic [20:0] in,
    output logic [55:0] segs
);
    typedef enum logic [1:0] {LOAD, SHIFT, UPDATE} state_t;
    state_t      state, nxt;
    logic [4:0]  cnt;
    logic [20:0] sr;
    logic [27:0] bcd, adj, disp;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7f;
        endcase
    endfunction
    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= LOAD;
        else      state <= nxt;
    // LOAD -> 21 x SHIFT -> UPDATE -> LOAD, giving a 23-clock period
    always_comb begin
        nxt = LOAD;
        nxt = (state == LOAD)  ? SHIFT :
              (state == SHIFT) ? ((cnt == 5'd20) ? UPDATE : SHIFT) : LOAD;
    end
    // add 3 to every BCD nibble of 5 or more ahead of the shift
    always_comb begin
        adj = bcd;
        for (int i = 0; i < 7; i++)
            adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // conversion datapath; only UPDATE touches the display register, so a reset mid-conversion leaves nothing partial
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt  <= '0;
            sr   <= '0;
            bcd  <= '0;
            disp <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
            sr  <= in;
            bcd <= '0;
        end else if (state == SHIFT) begin
            cnt       <= cnt + 5'd1;
            {bcd, sr} <= {adj[26:0], sr, 1'b0};
        end else if (state == UPDATE) begin
            disp <= bcd;
        end
    // decode with leading-zero blanking; digit 0 is always shown and digit 7 is always blank
    always_comb begin
        logic seen;
        seen = 1'b0;
        segs = {56{1'b1}};
        for (int k = 6; k >= 0; k--) begin
            seen = seen | (disp[4*k +: 4] != 4'd0) | (k == 0);
            segs[7*k +: 7] = seen ? seg7(disp[4*k +: 4]) : 7'h7f;
        end
    end
endmodule

// File: tb/tb_project287_display.sv
// tb_project287_display: scoreboard bench with a decimal-arithmetic display model
module tb_project287_display;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [20:0] din = 21'd23;
    logic [55:0] segs;
    int          checks = 0;
    int          errors = 0;
    int          since = 0;
    logic [55:0] q[$];
    logic [55:0] cur;
    logic [6:0]  lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [55:0] ZERO  = {{7{7'h7f}}, 7'h40};
    localparam logic [55:0] E23   = {{6{7'h7f}}, 7'h24, 7'h30};
    localparam logic [55:0] E100  = {{5{7'h7f}}, 7'h79, 7'h40, 7'h40};
    localparam logic [55:0] E1000 = {{4{7'h7f}}, 7'h79, 7'h40, 7'h40, 7'h40};
    localparam logic [55:0] EMAX  = {7'h7f, 7'h24, 7'h40, 7'h10, 7'h78, 7'h79, 7'h12, 7'h79};

    project287_display dut (.clk(clk), .rst(rst), .in(din), .segs(segs));

    always #5 clk = ~clk;

    function automatic logic [55:0] model(input int v);
        int d [7];
        int top, div;
        logic [55:0] r;
        top = 0;
        div = 1;
        for (int k = 0; k < 7; k++) begin
            d[k] = (v / div) % 10;
            if (d[k] != 0) top = k;
            div = div * 10;
        end
        r = {56{1'b1}};
        for (int k = 0; k <= top; k++) r[7*k +: 7] = lut[d[k]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [55:0] exp);
        checks++;
        if (segs !== exp) begin
            errors++;
            $display("FAIL %s: segs=%h expected=%h at %0t", name, segs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic to_phase(input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((since % 23 != p) && n < 200);
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout: phase=%0d wanted=%0d", since % 23, p);
        end
    endtask

    // sampler: the edge after each completed period (or after release) loads in
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            q.delete();
            since = 0;
        end else begin
            if (since % 23 == 0) q.push_back(model(int'(din)));
            since++;
        end
    end

    // monitor: a new display value is due after every 23rd edge; otherwise segs must hold
    initial begin
        cur = ZERO;
        forever begin
            @(negedge clk);
            if (!rst) cur = ZERO;
            else if (since > 0 && since % 23 == 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: no expected value at since=%0d", since);
                end else cur = q.pop_front();
            end
            checks++;
            if (segs !== cur) begin
                errors++;
                $display("FAIL monitor: segs=%h expected=%h since=%0d at %0t", segs, cur, since, $time);
            end
        end
    end

    initial begin
        int v, mode, wait_n;
        repeat (3) step();
        chk("reset_zero", ZERO);
        rst = 1'b1;
        to_phase(22);
        chk("hold_before_update", ZERO);
        step();
        chk("first_update_23", E23);
        repeat (92) step();
        chk("stable_23", E23);
        to_phase(10);
        din = 21'd1000;
        to_phase(0);
        chk("mid_change_old", E23);
        to_phase(0);
        chk("mid_change_new", E1000);
        din = 21'd23;
        to_phase(0);
        chk("back_to_23", E23);
        to_phase(10);
        rst = 1'b0;
        #1;
        chk("async_reset", ZERO);
        repeat (5) step();
        rst = 1'b1;
        repeat (22) step();
        chk("reset_hold", ZERO);
        step();
        chk("reset_recover_23", E23);
        din = 21'd2097151;
        to_phase(0);
        to_phase(0);
        chk("max_value", EMAX);
        din = 21'd0;
        to_phase(0);
        to_phase(0);
        chk("zero_value", ZERO);
        din = 21'd100;
        to_phase(0);
        to_phase(0);
        chk("internal_zeros", E100);
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 3);
            v = (mode == 0) ? $urandom_range(0, 2097151) :
                (mode == 1) ? $urandom_range(0, 999) :
                (mode == 2) ? $urandom_range(0, 9) : 2097151 - $urandom_range(0, 20);
            din = v[20:0];
            wait_n = $urandom_range(1, 40);
            repeat (wait_n) step();
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 6)) step();
                rst = 1'b1;
            end
        end
        repeat (50) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
